// File: rtl/writeback_unit.sv
// Final pipeline stage: selects ALU, load or link result and drives the regfile write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_unit #(
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_reg_wr,
    input  logic        in_mem_to_reg,
    input  logic        in_link,
    input  logic [4:0]  in_wr_addr,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_load_type,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        wb_busy,
    output logic        reg_wr,
    output logic [4:0]  reg_wr_addr,
    output logic [31:0] reg_wr_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic [31:0] retire_count
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t      state, state_nx;
    logic        p_reg_wr;
    logic [4:0]  p_addr;
    logic [2:0]  p_type;
    logic [1:0]  p_off;

    logic        slot;
    logic        slot_wr;
    logic [4:0]  slot_addr;
    logic [31:0] slot_data;

    function automatic logic [31:0] extract(
        input logic [2:0]  t,
        input logic [1:0]  off,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        state_nx  = state;
        slot      = 1'b0;
        slot_wr   = 1'b0;
        slot_addr = 5'd0;
        slot_data = 32'd0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!in_mem_to_reg || in_link) begin
                        slot      = 1'b1;
                        slot_wr   = in_reg_wr;
                        slot_addr = in_wr_addr;
                        slot_data = in_link ? in_pc + LINK_OFFSET
                                            : in_alu_result;
                    end else if (mem_rd_valid) begin
                        slot      = 1'b1;
                        slot_wr   = in_reg_wr;
                        slot_addr = in_wr_addr;
                        slot_data = extract(in_load_type,
                                            in_alu_result[1:0],
                                            mem_rd_data);
                    end else begin
                        state_nx = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rd_valid) begin
                    slot      = 1'b1;
                    slot_wr   = p_reg_wr;
                    slot_addr = p_addr;
                    slot_data = extract(p_type, p_off, mem_rd_data);
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            reg_wr      <= 1'b0;
            reg_wr_addr <= 5'd0;
            reg_wr_data <= 32'd0;
            p_reg_wr    <= 1'b0;
            p_addr      <= 5'd0;
            p_type      <= 3'd0;
            p_off       <= 2'd0;
        end else begin
            state  <= state_nx;
            reg_wr <= slot && slot_wr && (slot_addr != 5'd0);
            if (slot) begin
                reg_wr_addr <= slot_addr;
                reg_wr_data <= slot_data;
            end
            // Bundle is only held while a load waits for its data.
            if (state == IDLE && in_valid) begin
                p_reg_wr <= in_reg_wr;
                p_addr   <= in_wr_addr;
                p_type   <= in_load_type;
                p_off    <= in_alu_result[1:0];
            end
        end
    end

    assign wb_busy   = (state == WAIT_LOAD);
    assign fwd_valid = reg_wr;
    assign fwd_addr  = reg_wr_addr;
    assign fwd_data  = reg_wr_data;

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            retire_count <= 32'd0;
        else if (slot)
            retire_count <= retire_count + 32'd1;
    end
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed bundles push expected writes,
// a negedge monitor pops and compares every reg_wr pulse.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_reg_wr, in_mem_to_reg, in_link;
    logic [4:0]  in_wr_addr;
    logic [31:0] in_alu_result, in_pc, mem_rd_data;
    logic [2:0]  in_load_type;
    logic        mem_rd_valid;
    logic        wb_busy, reg_wr, fwd_valid;
    logic [4:0]  reg_wr_addr, fwd_addr;
    logic [31:0] reg_wr_data, fwd_data, retire_count;

    int total = 0;
    int bad = 0;
    int retired = 0;
    logic [36:0] exp_q[$];

    writeback_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_reg_wr(in_reg_wr),
        .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
        .in_wr_addr(in_wr_addr), .in_alu_result(in_alu_result),
        .in_pc(in_pc), .in_load_type(in_load_type),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .wb_busy(wb_busy), .reg_wr(reg_wr),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr: got addr %0d data %h expected none",
                         reg_wr_addr, reg_wr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, reg_wr_addr}, {27'd0, e[36:32]});
                chk("wr_data", reg_wr_data, e[31:0]);
                chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
                chk("fwd_addr", {27'd0, fwd_addr}, {27'd0, e[36:32]});
                chk("fwd_data", fwd_data, e[31:0]);
            end
        end
    end

    task automatic issue(input logic link, input logic m2r, input logic rw,
                         input logic [4:0] a, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [2:0] lt,
                         input logic mv, input logic [31:0] md);
        in_valid      = 1'b1;
        in_link       = link;
        in_mem_to_reg = m2r;
        in_reg_wr     = rw;
        in_wr_addr    = a;
        in_alu_result = alu;
        in_pc         = pc;
        in_load_type  = lt;
        mem_rd_valid  = mv;
        mem_rd_data   = md;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        mem_rd_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_load(input int n, input logic [31:0] md);
        for (int i = 0; i < n; i++) begin
            chk("busy_wait", {31'd0, wb_busy}, 32'd1);
            if (i == n - 1) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = md;
            end
            @(posedge clk);
            #1;
        end
        mem_rd_valid = 1'b0;
        chk("busy_fall", {31'd0, wb_busy}, 32'd0);
    endtask

    task automatic chk_count();
        logic [31:0] e;
`ifdef WB_RETIRE_COUNT_EN
        e = retired;
`else
        e = 32'd0;
`endif
        chk("retire_count", retire_count, e);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_reg_wr = 0; in_mem_to_reg = 0; in_link = 0;
        in_wr_addr = 0; in_alu_result = 0; in_pc = 0; in_load_type = 0;
        mem_rd_valid = 0; mem_rd_data = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
        chk("rst_addr", {27'd0, reg_wr_addr}, 32'd0);
        chk("rst_data", reg_wr_data, 32'd0);
        chk("rst_fwd", {fwd_valid, fwd_addr, fwd_data[25:0]}, 32'd0);
        chk("rst_busy", {31'd0, wb_busy}, 32'd0);
        chk("rst_count", retire_count, 32'd0);

        // ALU write, one-cycle pulse
        expect_wr(5'd5, 32'h12345678); retired++;
        issue(0, 0, 1, 5'd5, 32'h12345678, 32'h0, 3'b010, 0, 32'h0);
        @(posedge clk);
        #1;
        chk("pulse_low", {31'd0, reg_wr}, 32'd0);

        // LB offset 3, data after 3 wait cycles
        expect_wr(5'd6, 32'hFFFFFF80); retired++;
        issue(0, 1, 1, 5'd6, 32'h00001003, 32'h0, 3'b000, 0, 32'h0);
        wait_load(3, 32'h80FF0011);

        // LBU, with a bundle arriving during the wait that must be ignored
        expect_wr(5'd7, 32'h00000080); retired++;
        issue(0, 1, 1, 5'd7, 32'h00001003, 32'h0, 3'b100, 0, 32'h0);
        in_valid = 1'b1; in_mem_to_reg = 0; in_wr_addr = 5'd9;
        in_alu_result = 32'hDEADBEEF;
        wait_load(2, 32'h80FF0011);
        in_valid = 1'b0;

        // LH offset 2, data in acceptance cycle
        expect_wr(5'd8, 32'hFFFF9ABC); retired++;
        issue(0, 1, 1, 5'd8, 32'h00002002, 32'h0, 3'b001, 1, 32'h9ABC1234);
        chk("lh_nobusy", {31'd0, wb_busy}, 32'd0);

        // LHU offset 1 uses low half; code 011 behaves as LW
        expect_wr(5'd10, 32'h0000F234); retired++;
        issue(0, 1, 1, 5'd10, 32'h00002001, 32'h0, 3'b101, 1, 32'h9ABCF234);
        expect_wr(5'd11, 32'h9ABCF234); retired++;
        issue(0, 1, 1, 5'd11, 32'h00002003, 32'h0, 3'b011, 1, 32'h9ABCF234);

        // Link overrides mem_to_reg; back-to-back with following bundles
        expect_wr(5'd31, 32'h00400018); retired++;
        issue(1, 1, 1, 5'd31, 32'h11111111, 32'h00400010, 3'b010, 0, 32'h0);
        expect_wr(5'd1, 32'h00000000); retired++;
        issue(1, 0, 1, 5'd1, 32'h0, 32'hFFFFFFF8, 3'b010, 0, 32'h0);
        // Suppressed writes still retire
        retired++;
        issue(0, 0, 1, 5'd0, 32'hCAFEF00D, 32'h0, 3'b010, 0, 32'h0);
        retired++;
        issue(0, 0, 0, 5'd3, 32'hCAFEF00D, 32'h0, 3'b010, 0, 32'h0);
        expect_wr(5'd2, 32'h00000042); retired++;
        issue(0, 0, 1, 5'd2, 32'h00000042, 32'h0, 3'b010, 0, 32'h0);
        @(posedge clk);
        #1;
        chk_count();

        // Reset during WAIT_LOAD discards the pending load
        issue(0, 1, 1, 5'd12, 32'h0, 32'h0, 3'b010, 0, 32'h0);
        chk("busy_pre_rst", {31'd0, wb_busy}, 32'd1);
        reset = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 32'h55555555;
        @(posedge clk);
        #1;
        reset = 1'b0; retired = 0;
        @(posedge clk);
        #1;
        mem_rd_valid = 1'b0;
        chk("rst_wait_busy", {31'd0, wb_busy}, 32'd0);
        chk("rst_wait_wr", {31'd0, reg_wr}, 32'd0);
        chk("rst_wait_count", retire_count, 32'd0);

        // Ten more retirements
        for (int i = 0; i < 10; i++) begin
            expect_wr(5'd20, 32'h100 + i); retired++;
            issue(0, 0, 1, 5'd20, 32'h100 + i, 32'h0, 3'b010, 0, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_count();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage that accepts the MEM/WB bundle, forms the result and drives the register file write port (`reg_wr`, `reg_wr_addr`, `reg_wr_data`). It selects among the ALU result, extracted load data and the link address. It waits on variable-latency load data, stalling upstream meanwhile. It also publishes the write as a forwarding source for decode/execute and optionally counts retired instructions.

## Interface
Parameters:
- `LINK_OFFSET`, default 8: added to `in_pc` for link writes.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  MEM/WB bundle present this cycle.
- `in_reg_wr`  in  1  instruction writes a register.
- `in_mem_to_reg`  in  1  result comes from load data.
- `in_link`  in  1  result is `in_pc + LINK_OFFSET`; overrides `in_mem_to_reg`.
- `in_wr_addr`  in  5  destination register.
- `in_alu_result`  in  32  ALU result; bits [1:0] are the load byte offset.
- `in_pc`  in  32  PC of the instruction.
- `in_load_type`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes treated as LW.
- `mem_rd_data`  in  32  load word from data memory.
- `mem_rd_valid`  in  1  `mem_rd_data` valid this cycle.
- `wb_busy`  out  1  upstream must hold its bundle; combinational from state.
- `reg_wr`  out  1  register file write enable, one-cycle pulse.
- `reg_wr_addr`  out  5  write address.
- `reg_wr_data`  out  32  write data.
- `fwd_valid`, `fwd_addr`, `fwd_data`  out  1/5/32  registered copy of the write, for forwarding.
- `retire_count`  out  32  retired instruction count.

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, `in_valid`=1, not a load (`in_mem_to_reg`=0 or `in_link`=1):
  - accept;
  - next cycle drive the write;
  - stay IDLE.
- IDLE, `in_valid`=1, load: latch the bundle.
  - If `mem_rd_valid`=1 in the same cycle, write next cycle and stay IDLE.
  - Otherwise go to WAIT_LOAD.
- WAIT_LOAD:
  - `wb_busy`=1; `in_valid` is ignored.
  - On `mem_rd_valid`=1, write next cycle and go to IDLE.
- `mem_rd_valid` in IDLE with no accepted load: ignored.
- Load extraction, little-endian, offset `off` = `in_alu_result[1:0]`:
  - LB/LBU: byte `mem_rd_data[8*off+7:8*off]`, sign- or zero-extended.
  - LH/LHU: half `off[1] ? [31:16] : [15:0]`; `off[0]` ignored.
  - LW: whole word, offset ignored.
- Link data: `in_pc + LINK_OFFSET`, modulo 2^32.
- Write suppression: `reg_wr`=0 when `in_reg_wr`=0 or address is 0. The instruction still retires.
- `fwd_*` equal the `reg_wr`/`reg_wr_addr`/`reg_wr_data` of the same cycle.

## Timing
- Reset values: state IDLE; `reg_wr`=0, `reg_wr_addr`=0, `reg_wr_data`=0, `fwd_valid`=0, `fwd_addr`=0, `fwd_data`=0, `retire_count`=0, `wb_busy`=0.
- Latency:
  - non-load, or load with data in the acceptance cycle: write asserted 1 cycle after acceptance;
  - waited load: write asserted 1 cycle after `mem_rd_valid` is sampled.
- `reg_wr` is high for exactly one cycle per writing instruction. Back-to-back non-load bundles give `reg_wr` on consecutive cycles.
- `wb_busy` rises the cycle after a load is accepted without data, and falls the cycle after `mem_rd_valid` is sampled.
- `reset` during WAIT_LOAD: the pending write is discarded, no `reg_wr` is produced, state returns to IDLE.
- `reset` wins over simultaneous `in_valid` or `mem_rd_valid`.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - `retire_count` increments by 1 in the cycle each instruction's write slot occurs, including suppressed writes;
  - wraps 0xFFFFFFFF→0.
- `WB_RETIRE_COUNT_EN` undefined: no counter logic; `retire_count` tied to 0.

## Test plan
- After reset, bundle ALU result 0x12345678, dest 5, `in_reg_wr`=1 → next cycle `reg_wr`=1, addr 5, data 0x12345678, `fwd_valid`=1; one cycle later `reg_wr`=0.
- Load LB, offset 3, `mem_rd_valid` 3 cycles after acceptance with data 0x80FF0011 → `wb_busy`=1 for 3 cycles, then write 0xFFFFFF80; the same as LBU writes 0x00000080.
- LH offset 2 with data 0x9ABC1234 in the acceptance cycle → write 0xFFFF9ABC next cycle, `wb_busy` never high.
- `in_link`=1, `in_pc`=0x00400010, dest 31 → write 0x00400018; dest 0 with `in_reg_wr`=1 → no `reg_wr`, `retire_count` +1 when the macro is defined.
- `reset` in WAIT_LOAD, then `mem_rd_valid`=1 → no write; `wb_busy`=0; counter 0.
- Macro undefined, 10 retired instructions → `retire_count` stays 0.
